// File: rtl/eth_mdio_pkg.sv
// rtl/eth_mdio_pkg.sv - Clause-22 MDIO frame constants, state type and frame helpers
package eth_mdio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_HEADER,
        ST_TA,
        ST_DATA,
        ST_FINISH
    } mdio_state_e;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam int PREAMBLE_BITS = 32;
    localparam int FRAME_BITS    = 64;
    localparam int TA_BIT        = 46;
    localparam int DATA_BIT      = 48;

    // Read frames carry TA/data placeholders here; those bits are never driven.
    function automatic logic [63:0] build_frame(input logic wr, input logic [4:0] phy_addr,
                                                input logic [4:0] reg_addr, input logic [15:0] data);
        return {{PREAMBLE_BITS{1'b1}}, MDIO_ST, (wr ? MDIO_OP_WR : MDIO_OP_RD),
                phy_addr, reg_addr, 2'b10, data};
    endfunction

    function automatic mdio_state_e bit_state(input logic [5:0] bit_idx);
        if (bit_idx < 6'(PREAMBLE_BITS)) return ST_PREAMBLE;
        else if (bit_idx < 6'(TA_BIT))   return ST_HEADER;
        else if (bit_idx < 6'(DATA_BIT)) return ST_TA;
        else                             return ST_DATA;
    endfunction

endpackage

// File: rtl/eth_mdio_master_mdc_clk_gen.sv
// rtl/eth_mdio_master_mdc_clk_gen.sv - MDC divider with bit-start and MDC-rise strobes
module mdc_clk_gen #(
    parameter int MDC_DIV = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic mdc,
    output logic bit_start,
    output logic mdc_rise
);
    localparam int DW = $clog2(MDC_DIV);
    localparam logic [DW-1:0] LAST = DW'(MDC_DIV - 1);
    localparam logic [DW-1:0] HALF = DW'(MDC_DIV / 2);
    localparam logic [DW-1:0] RISE = DW'(MDC_DIV / 2 - 1);

    logic [DW-1:0] div_q, div_d;
    logic          mdc_q, mdc_d;

    always_comb begin
        div_d = '0;
        if (en) begin
            div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
        end
        mdc_d = en && (div_d >= HALF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            div_q <= div_d;
            mdc_q <= mdc_d;
        end
    end

    // Strobes qualify the edge that ends the current clock: bit_start launches the next bit.
    assign bit_start = en && (div_q == LAST);
    assign mdc_rise  = en && (div_q == RISE);
    assign mdc       = mdc_q;

endmodule

// File: rtl/eth_mdio_master.sv
// rtl/eth_mdio_master.sv - Clause-22 MDIO master serving the DM_* register bank
module eth_mdio_master
    import eth_mdio_pkg::*;
#(
    parameter int MDC_DIV = 40
) (
    input  logic        clk_100_mhz,
    input  logic        rst_n,
    input  logic        DM_start,
    input  logic        DM_mode,
    input  logic [4:0]  DM_addr,
    input  logic [4:0]  DM_reg_addr,
    input  logic [15:0] DM_data_i,
    output logic [15:0] DM_data_o,
    output logic        DM_done,
    output logic        DM_err,
    output logic        MDC,
    inout  wire         MDIO
);
    mdio_state_e state_q, state_d;
    logic [5:0]  bit_q, bit_d;
    logic [63:0] frame_q, frame_d;
    logic [15:0] rd_shift_q, rd_shift_d;
    logic [15:0] data_o_q, data_o_d;
    logic [1:0]  sync_q, sync_d;
    logic        wr_q, wr_d;
    logic        mdio_oe_q, mdio_oe_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        start_prev_q, start_prev_d;
    logic        start_pulse_q, start_pulse_d;
    logic        busy, bit_start, mdc_rise;

    assign busy = (state_q != ST_IDLE);

    mdc_clk_gen #(.MDC_DIV(MDC_DIV)) u_mdc_clk_gen (
        .clk       (clk_100_mhz),
        .rst_n     (rst_n),
        .en        (busy),
        .mdc       (MDC),
        .bit_start (bit_start),
        .mdc_rise  (mdc_rise)
    );

    always_comb begin
        state_d       = state_q;
        bit_d         = bit_q;
        frame_d       = frame_q;
        rd_shift_d    = rd_shift_q;
        data_o_d      = data_o_q;
        wr_d          = wr_q;
        mdio_oe_d     = mdio_oe_q;
        done_d        = done_q;
        err_d         = err_q;
        start_prev_d  = DM_start;
        start_pulse_d = DM_start & ~start_prev_q;
        sync_d        = {sync_q[0], MDIO};

        if (state_q == ST_IDLE) begin
            if (start_pulse_q) begin
                state_d   = ST_PREAMBLE;
                bit_d     = 6'd0;
                frame_d   = build_frame(DM_mode, DM_addr, DM_reg_addr, DM_data_i);
                wr_d      = DM_mode;
                mdio_oe_d = 1'b1;
                done_d    = 1'b0;
                err_d     = 1'b0;
            end
        end else begin
            if (mdc_rise && !wr_q) begin
                // A PHY that answers pulls the second TA bit low; an idle bus stays high.
                if (bit_q == 6'(DATA_BIT - 1) && sync_q[1]) begin
                    err_d = 1'b1;
                end
                if (state_q == ST_DATA) begin
                    rd_shift_d = {rd_shift_q[14:0], sync_q[1]};
                end
            end
            if (bit_start) begin
                if (state_q == ST_FINISH) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (!wr_q) begin
                        data_o_d = rd_shift_q;
                    end
                end else begin
                    bit_d   = bit_q + 6'd1;
                    frame_d = {frame_q[62:0], 1'b0};
                    if (bit_q == 6'(FRAME_BITS - 1)) begin
                        state_d   = ST_FINISH;
                        mdio_oe_d = 1'b0;
                    end else begin
                        state_d   = bit_state(bit_d);
                        mdio_oe_d = wr_q || (bit_d < 6'(TA_BIT));
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_100_mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bit_q         <= '0;
            frame_q       <= '0;
            rd_shift_q    <= '0;
            data_o_q      <= '0;
            sync_q        <= '0;
            wr_q          <= 1'b0;
            mdio_oe_q     <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            start_prev_q  <= 1'b0;
            start_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_q         <= bit_d;
            frame_q       <= frame_d;
            rd_shift_q    <= rd_shift_d;
            data_o_q      <= data_o_d;
            sync_q        <= sync_d;
            wr_q          <= wr_d;
            mdio_oe_q     <= mdio_oe_d;
            done_q        <= done_d;
            err_q         <= err_d;
            start_prev_q  <= start_prev_d;
            start_pulse_q <= start_pulse_d;
        end
    end

    assign MDIO      = mdio_oe_q ? frame_q[63] : 1'bz;
    assign DM_data_o = data_o_q;
    assign DM_done   = done_q;
    assign DM_err    = err_q;

endmodule

// File: tb/tb_eth_mdio_master.sv
// tb/tb_eth_mdio_master.sv - self-checking bench for eth_mdio_master
module tb_eth_mdio_master;

    localparam int DIV = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        DM_start = 1'b0;
    logic        DM_mode = 1'b0;
    logic [4:0]  DM_addr = '0;
    logic [4:0]  DM_reg_addr = '0;
    logic [15:0] DM_data_i = '0;
    logic [15:0] DM_data_o;
    logic        DM_done, DM_err, MDC;
    wire         mdio;
    logic        phy_en = 1'b1;
    logic        phy_bit = 1'b1;

    logic        s4_start = 1'b0;
    logic [15:0] s4_data_o;
    logic        s4_done, s4_err, mdc4;
    wire         mdio4;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign mdio = phy_en ? phy_bit : 1'bz;

    eth_mdio_master #(.MDC_DIV(DIV)) dut (
        .clk_100_mhz (clk),
        .rst_n       (rst_n),
        .DM_start    (DM_start),
        .DM_mode     (DM_mode),
        .DM_addr     (DM_addr),
        .DM_reg_addr (DM_reg_addr),
        .DM_data_i   (DM_data_i),
        .DM_data_o   (DM_data_o),
        .DM_done     (DM_done),
        .DM_err      (DM_err),
        .MDC         (MDC),
        .MDIO        (mdio)
    );

    eth_mdio_master #(.MDC_DIV(4)) dut4 (
        .clk_100_mhz (clk),
        .rst_n       (rst_n),
        .DM_start    (s4_start),
        .DM_mode     (1'b1),
        .DM_addr     (5'h07),
        .DM_reg_addr (5'h11),
        .DM_data_i   (16'h5A5A),
        .DM_data_o   (s4_data_o),
        .DM_done     (s4_done),
        .DM_err      (s4_err),
        .MDC         (mdc4),
        .MDIO        (mdio4)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  pa;
        logic [4:0]  ra;
        logic [15:0] din;
        logic [15:0] phy_d;
        logic        no_phy;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one transaction on the default-divider DUT; abort_bit >= 0 pulls reset at that bit.
    task automatic run_txn(input vec_t v, input int abort_bit);
        logic [63:0] obs, oe_obs, exp_f, exp_mask;
        logic        mdc_prev, done_prev;
        int          cyc, rises, falls, rise_at;
        exp_f    = {32'hFFFF_FFFF, 2'b01, (v.wr ? 2'b01 : 2'b10), v.pa, v.ra, 2'b10, v.din};
        exp_mask = v.wr ? ~64'd0 : (~64'd0 << 18);
        @(negedge clk);
        phy_en = 1'b0; phy_bit = 1'b1;
        DM_mode = v.wr; DM_addr = v.pa; DM_reg_addr = v.ra; DM_data_i = v.din;
        DM_start = 1'b1;
        @(posedge clk); #1;
        cyc = 0; rises = 0; falls = 0; rise_at = -1;
        obs = '0; oe_obs = '0;
        mdc_prev = MDC; done_prev = DM_done;
        while (cyc < 65 * DIV + 10) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 3) DM_start = 1'b0;
            if (MDC && !mdc_prev) begin
                if (rises < 64) begin
                    obs[63 - rises]    = mdio;
                    oe_obs[63 - rises] = dut.mdio_oe_q;
                end
                rises++;
            end
            if (!MDC && mdc_prev) begin
                falls++;
                if (falls >= (v.wr ? 64 : 46)) phy_en = 1'b1;
                if (!v.wr) begin
                    if (v.no_phy || falls == 46 || falls > 63) phy_bit = 1'b1;
                    else if (falls == 47)                      phy_bit = 1'b0;
                    else if (falls >= 48)                      phy_bit = v.phy_d[63 - falls];
                end
                if (abort_bit >= 0 && falls == abort_bit) begin
                    #2 rst_n = 1'b0;
                    #1;
                    check("rst_mdc", 64'(MDC), 64'd0);
                    check("rst_oe", 64'(dut.mdio_oe_q), 64'd0);
                    check("rst_done", 64'(DM_done), 64'd0);
                    check("rst_data", 64'(DM_data_o), 64'd0);
                    check("rst_err", 64'(DM_err), 64'd0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
            end
            if (DM_done && !done_prev && rise_at < 0) rise_at = cyc;
            mdc_prev  = MDC;
            done_prev = DM_done;
        end
        check("frame_bits", obs & exp_mask, exp_f & exp_mask);
        check("oe_window", oe_obs, exp_mask);
        check("done_at", 64'(rise_at), 64'(65 * DIV + 1));
        check("data_o", 64'(DM_data_o), 64'(v.exp_data));
        check("err", 64'(DM_err), 64'(v.exp_err));
        check("mdc_idle", 64'(MDC), 64'd0);
    endtask

    initial begin
        vec_t v;
        logic [15:0] model_last;
        logic        done_prev, exp_m;
        int          n_rises, rise_at, bad;

        vecs.push_back('{1'b1, 5'h01, 5'h00, 16'h1200, 16'h0000, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 5'h01, 5'h02, 16'h0000, 16'h0007, 1'b0, 16'h0007, 1'b0});
        vecs.push_back('{1'b0, 5'h01, 5'h02, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1});
        model_last = 16'hFFFF;
        for (int i = 0; i < 6; i++) begin
            v.wr     = 1'($urandom_range(0, 1));
            v.pa     = 5'($urandom);
            v.ra     = 5'($urandom);
            v.din    = 16'($urandom);
            v.phy_d  = 16'($urandom);
            v.no_phy = ($urandom_range(0, 3) == 0);
            if (!v.wr) model_last = v.no_phy ? 16'hFFFF : v.phy_d;
            v.exp_data = model_last;
            v.exp_err  = !v.wr && v.no_phy;
            vecs.push_back(v);
        end

        #23;
        check("reset_done", 64'(DM_done), 64'd0);
        check("reset_err", 64'(DM_err), 64'd0);
        check("reset_data", 64'(DM_data_o), 64'd0);
        check("reset_mdc", 64'(MDC), 64'd0);
        check("reset_oe", 64'(dut.mdio_oe_q), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        foreach (vecs[i]) run_txn(vecs[i], -1);

        // Held-high start with an extra edge mid-frame: one transaction only.
        @(negedge clk);
        phy_en = 1'b0;
        DM_mode = 1'b1; DM_addr = 5'h03; DM_reg_addr = 5'h04; DM_data_i = 16'hBEEF;
        DM_start = 1'b1;
        @(posedge clk); #1;
        n_rises = 0; rise_at = -1; done_prev = DM_done;
        for (int c = 1; c <= 5400; c++) begin
            @(posedge clk); #1;
            if (c == 1300) DM_start = 1'b0;
            if (c == 1310) DM_start = 1'b1;
            if (c == 64 * DIV + 1) phy_en = 1'b1;
            if (DM_done && !done_prev) begin
                n_rises++;
                if (rise_at < 0) rise_at = c;
            end
            done_prev = DM_done;
        end
        check("held_rises", 64'(n_rises), 64'd1);
        check("held_done_at", 64'(rise_at), 64'(65 * DIV + 1));
        check("held_done_level", 64'(DM_done), 64'd1);
        DM_start = 1'b0;
        repeat (3) @(posedge clk);

        // Reset at bit 50 of a read, then a clean read afterwards.
        v = '{1'b0, 5'h1F, 5'h1E, 16'h0000, 16'h1234, 1'b0, 16'h1234, 1'b0};
        run_txn(v, 50);
        repeat (3) @(posedge clk);
        v = '{1'b0, 5'h02, 5'h05, 16'h0000, 16'hA5C3, 1'b0, 16'hA5C3, 1'b0};
        run_txn(v, -1);

        // Divide-by-4 instance: 2 low / 2 high MDC, done at 65*4+1.
        @(negedge clk);
        s4_start = 1'b1;
        @(posedge clk); #1;
        bad = 0; rise_at = -1; done_prev = s4_done;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            if (c == 3) s4_start = 1'b0;
            exp_m = (c <= 260) ? (((c - 1) % 4) >= 2) : 1'b0;
            if (mdc4 !== exp_m) bad++;
            if (s4_done && !done_prev && rise_at < 0) rise_at = c;
            done_prev = s4_done;
        end
        check("div4_mdc_pattern", 64'(bad), 64'd0);
        check("div4_done_at", 64'(rise_at), 64'd261);
        check("div4_err", 64'(s4_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_mdio_master.md
# eth_mdio_master

Clause-22 MDIO management master driven by the DM_* register bank of the AXI Ethernet peripheral. It sits directly downstream of the AXI register block: it consumes DM_start/DM_mode/DM_addr/DM_reg_addr/DM_data_i, runs one PHY register read or write on MDC/MDIO, and returns DM_data_o, DM_done and DM_err for CPU polling.

## Interface
- MDC_DIV, 40: system clocks per MDC period; even, ≥4 (100 MHz / 40 = 2.5 MHz MDC).
- clk_100_mhz  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- DM_start  in  1  level register; a 0→1 transition starts a transaction.
- DM_mode  in  1  1 = write, 0 = read; sampled at start.
- DM_addr  in  5  PHY address; sampled at start.
- DM_reg_addr  in  5  PHY register address; sampled at start.
- DM_data_i  in  16  write data; sampled at start.
- DM_data_o  out  16  last read data; reset 16'h0.
- DM_done  out  1  level; high after completion until next start; reset 0.
- DM_err  out  1  read turnaround error (no PHY response); reset 0.
- MDC  out  1  management clock; reset 0, idles low.
- MDIO  inout  1  driven when output enable is set, else high-Z.

## Operation
- Start: previous DM_start registered; edge = DM_start & ~prev. Accepted only in IDLE; edges while busy are ignored; a held-high DM_start never retriggers.
- On accept: latch mode/addresses/data into a 64-bit frame: 32×'1' preamble, ST=01, OP (01 write / 10 read), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0]; MSB first. Clear DM_done and DM_err.
- States: IDLE → PREAMBLE (bits 0-31) → HEADER (bits 32-45) → TA (46-47) → DATA (48-63) → FINISH (one MDC period, MDIO released, MDC keeps toggling) → IDLE with DM_done=1.
- Write: MDIO driven for all 64 bits, TA = 1,0.
- Read: MDIO driven through bit 45; released (high-Z) from the start of bit 46. Sample at the bit-47 MDC rising edge: a 1 sets DM_err. Data bits 48-63 shift in MSB first; DM_data_o is updated with all 16 bits at completion only, also when DM_err=1 (holds the previous value during the transaction).
- MDIO input passes through a 2-flop synchronizer before sampling.

## Timing
- Bit period = MDC_DIV clocks. MDC is low for the first MDC_DIV/2 clocks and high for the second half.
- MDIO and output enable change only at the start of each bit (MDC falling point). Read samples are taken on the clock where MDC rises; the synchronizer delay of 2 clocks is well inside the half-period.
- Clock E samples the start edge; MDIO is driven from E+1.
- DM_done rises exactly 65×MDC_DIV+1 clocks after E (2601 at default).
- MDC is low in IDLE and after completion.
- Bit counter is 6 bits, 0..63. The divider counter is $clog2(MDC_DIV) bits and wraps at MDC_DIV-1.
- Async reset at any point: IDLE, MDC=0, MDIO released, all outputs at reset values. The transaction is abandoned and no DM_done is produced.

## Structure
- Package eth_mdio_pkg: state enum, MDIO_ST=2'b01, MDIO_OP_WR=2'b01, MDIO_OP_RD=2'b10, PREAMBLE_BITS=32, FRAME_BITS=64.
- Sub-module mdc_clk_gen: MDC_DIV divider with enable, producing MDC plus single-cycle bit_start and mdc_rise strobes. The FSM and shift registers stay in eth_mdio_master.

## Test plan
- Write PHY 5'h01, reg 5'h00, data 16'h1200 → MDIO bitstream equals 32 ones, 01 01 00001 00000 10 0001001000000000. Output enable is high for all 64 bits. DM_done=1 at clock 2601.
- Read PHY 5'h01, reg 5'h02, PHY model drives TA 0 and data 16'h0007 → DM_data_o=16'h0007, DM_err=0. Output enable falls at bit 46.
- Read with MDIO pulled high (no PHY) → DM_err=1, DM_data_o=16'hFFFF, DM_done=1.
- DM_start held high through and after completion, plus a second 0→1 edge mid-frame → exactly one transaction and one DM_done rise.
- rst_n asserted at bit 50 of a read → MDC=0 and MDIO high-Z immediately, DM_done=0, DM_data_o=0. A new start then completes normally.
- MDC_DIV=4 → MDC period 4 clocks with 2 low / 2 high. DM_done at 261 clocks.
